// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Iteration counter must hold the value N itself, hence clog2(N+1).
    function automatic int unsigned count_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/finished handshake and operand/result bus of the shift-and-add multiplier.
interface shift_add_multiplier_if #(
    parameter int unsigned N = 8
);
    logic             i_start;
    logic [N-1:0]     i_multiplicand;
    logic [N-1:0]     i_multiplier;
    logic             o_busy;
    logic             o_finished;
    logic [2*N-1:0]   o_product;
    logic             o_overflow;

    modport master (
        output i_start, i_multiplicand, i_multiplier,
        input  o_busy, o_finished, o_product, o_overflow
    );

    modport slave (
        input  i_start, i_multiplicand, i_multiplier,
        output o_busy, o_finished, o_product, o_overflow
    );
endinterface

// File: rtl/shift_add_multiplier_adder.sv
// N-bit ripple-carry adder with carry-out; mirror of the divider's subtractor.
module shift_add_multiplier_adder #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] i_augend,
    input  logic [N-1:0] i_addend,
    output logic [N-1:0] o_sum,
    output logic         o_carry
);

    always_comb begin
        logic c;
        c     = 1'b0;
        o_sum = '0;
        for (int i = 0; i < int'(N); i++) begin
            o_sum[i] = i_augend[i] ^ i_addend[i] ^ c;
            c        = (i_augend[i] & i_addend[i]) | (c & (i_augend[i] ^ i_addend[i]));
        end
        o_carry = c;
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one multiplier bit per cycle, N cycles per product,
// result announced by a one-cycle finished pulse and held until the next accepted start.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    shift_add_multiplier_if.slave bus
);

    localparam int unsigned CW = count_width(N);

    state_t           state;
    state_t           state_next;
    logic [N-1:0]     mcand;
    logic [2*N-1:0]   acc;
    logic [CW-1:0]    count;
    logic             accept;

    logic [N-1:0]     addend;
    logic [N-1:0]     sum;
    logic             carry;

    assign addend = acc[0] ? mcand : '0;

    shift_add_multiplier_adder #(.N(N)) u_adder (
        .i_augend (acc[2*N-1:N]),
        .i_addend (addend),
        .o_sum    (sum),
        .o_carry  (carry)
    );

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; starts are only taken when not iterating
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = bus.i_start;
                if (bus.i_start) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (count == CW'(1)) state_next = ST_DONE;
            end
            ST_DONE: begin
                accept     = bus.i_start;
                state_next = bus.i_start ? ST_RUN : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: load on accept, then add-and-shift right with the carry kept in the top bit
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            mcand <= '0;
            acc   <= '0;
            count <= '0;
        end else if (accept) begin
            mcand <= bus.i_multiplicand;
            acc   <= {N'(0), bus.i_multiplier};
            count <= CW'(N);
        end else if (state == ST_RUN) begin
            acc   <= {carry, sum, acc[N-1:1]};
            count <= count - CW'(1);
        end
    end

    assign bus.o_busy     = (state == ST_RUN);
    assign bus.o_finished = (state == ST_DONE);
    assign bus.o_product  = acc;
    assign bus.o_overflow = |acc[2*N-1:N];

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: stimulus pushes A*B, a monitor pops on finished.
module tb_shift_add_multiplier;

    localparam int unsigned N = 8;

    typedef struct packed {
        logic [2*N-1:0] product;
        logic           overflow;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];

    shift_add_multiplier_if #(.N(N)) bus ();

    shift_add_multiplier #(.N(N)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: plain arithmetic on the operands
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        e.product  = (2*N)'(a) * (2*N)'(b);
        e.overflow = (e.product >> N) != 0;
        return e;
    endfunction

    // Monitor: compare every finished pulse against the oldest expectation
    logic prev_fin = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_fin) check("finished_single_cycle", 64'(bus.o_finished), 64'd0);
            if (bus.o_finished) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_underflow: finished with product %0h, no result expected", bus.o_product);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("product", 64'(bus.o_product), 64'(e.product));
                    check("overflow", 64'(bus.o_overflow), 64'(e.overflow));
                end
            end
        end
        prev_fin = bus.o_finished;
    end

    // Drives a start; expects to be called #1 after an edge, returns #1 after the accept edge
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold);
        bus.i_start        = 1'b1;
        bus.i_multiplicand = a;
        bus.i_multiplier   = b;
        @(posedge clk);
        sb_q.push_back(model(a, b));
        #1;
        if (!hold) bus.i_start = 1'b0;
        bus.i_multiplicand = N'($urandom);
        bus.i_multiplier   = N'($urandom);
    endtask

    task automatic wait_done(input int exp_cycles, input string tag);
        int cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!bus.o_finished && cyc < int'(4*N));
        check({tag, "_latency"}, 64'(cyc), 64'(exp_cycles));
        check({tag, "_busy_in_done"}, 64'(bus.o_busy), 64'd0);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_start        = 1'b0;
        bus.i_multiplicand = '0;
        bus.i_multiplier   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", 64'(bus.o_busy), 64'd0);
        check("reset_finished", 64'(bus.o_finished), 64'd0);
        check("reset_product", 64'(bus.o_product), 64'd0);
        check("reset_overflow", 64'(bus.o_overflow), 64'd0);

        // 13*11 with timing of busy/finished
        start_op(8'd13, 8'd11, 1'b0);
        check("busy_after_accept", 64'(bus.o_busy), 64'd1);
        wait_done(N, "basic");
        idle_cycle();
        check("idle_finished_low", 64'(bus.o_finished), 64'd0);
        check("idle_product_held", 64'(bus.o_product), 64'h008F);

        start_op(8'd255, 8'd255, 1'b0);
        wait_done(N, "max");
        idle_cycle();
        check("max_overflow_held", 64'(bus.o_overflow), 64'd1);

        start_op(8'd0, 8'd200, 1'b0);
        wait_done(N, "zero_a");
        start_op(8'd200, 8'd0, 1'b0);
        wait_done(N, "zero_b");

        // start during RUN is ignored
        start_op(8'd3, 8'd5, 1'b0);
        repeat (3) idle_cycle();
        bus.i_start        = 1'b1;
        bus.i_multiplicand = 8'd7;
        bus.i_multiplier   = 8'd7;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        wait_done(N - 4, "ignored_start");
        for (int i = 0; i < 5; i++) begin
            idle_cycle();
            check("held_product", 64'(bus.o_product), 64'd15);
            check("held_not_busy", 64'(bus.o_busy), 64'd0);
        end

        // reset mid-run discards the partial product
        start_op(8'd6, 8'd7, 1'b0);
        void'(sb_q.pop_back());
        repeat (4) idle_cycle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset_busy", 64'(bus.o_busy), 64'd0);
        check("midreset_finished", 64'(bus.o_finished), 64'd0);
        check("midreset_product", 64'(bus.o_product), 64'd0);
        start_op(8'd9, 8'd9, 1'b0);
        wait_done(N, "after_reset");

        // back-to-back through DONE
        start_op(8'd10, 8'd10, 1'b1);
        bus.i_multiplicand = 8'd12;
        bus.i_multiplier   = 8'd12;
        wait_done(N, "b2b_first");
        @(posedge clk);
        sb_q.push_back(model(8'd12, 8'd12));
        #1;
        bus.i_start = 1'b0;
        check("b2b_no_idle", 64'(bus.o_busy), 64'd1);
        wait_done(N, "b2b_second");

        // random operands with random gaps (gap 0 exercises back-to-back)
        for (int i = 0; i < 24; i++) begin
            start_op(N'($urandom), N'($urandom), 1'b0);
            wait_done(N, "random");
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        repeat (3) idle_cycle();
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
Sequential unsigned shift-and-add multiplier. It is the inverse-direction companion to the restoring divider and uses the same start/finished control style. It computes product = multiplicand * multiplier over N iteration cycles, one multiplier bit per cycle, using a single N-bit adder. It is used wherever a full-width product is needed and single-cycle array multiplication is too costly.

Parameters:
N, 8, operand width in bits (N >= 2); product is 2N bits

Ports:
i_clock  input  1  system clock, all state updates on rising edge
i_reset  input  1  synchronous, active-high reset
i_start  input  1  request to begin; accepted only when not busy
i_multiplicand  input  N  unsigned operand A, sampled on accepted start
i_multiplier  input  N  unsigned operand B, sampled on accepted start
o_busy  output  1  high while iterating (RUN state)
o_finished  output  1  one-cycle pulse: o_product is valid
o_product  output  2N  A*B, held until next accepted start
o_overflow  output  1  high when o_product[2N-1:N] != 0 (result does not fit N bits); valid with/after o_finished

Behaviour:
- Clocking and reset are fixed: one clock (i_clock); i_reset is synchronous and active-high.
- Reset: state = IDLE. o_busy = 0, o_finished = 0, o_product = 0, o_overflow = 0, iteration counter = 0.
- States:
  - IDLE: waiting.
  - RUN: iterating.
  - DONE: one cycle, result announced.
- Start acceptance: i_start is accepted at a rising edge when state is IDLE or DONE. Otherwise it is ignored; there is no queuing.
- On the accept edge (edge 0):
  - Latch A into the multiplicand register.
  - Load accumulator P[2N-1:0] = {N'b0, B}.
  - Set counter = N.
  - Go to RUN.
- RUN, each edge 1..N:
  - {c, s} = P[2N-1:N] + (P[0] ? A : 0), where c is the adder carry-out.
  - P <= {c, s, P[N-1:1]}, i.e. a logical right shift including the carry.
  - Decrement counter. When counter reaches 1 at this edge, next state is DONE.
- Latency: with the start accepted at edge 0, the last iteration is at edge N. o_finished is high for exactly the cycle after edge N. Start-to-result latency is N+1 cycles.
- DONE:
  - o_finished = 1, o_busy = 0.
  - Next state is RUN if i_start is asserted (back-to-back operation with no idle cycle), otherwise IDLE.
- o_product = P. It is visible during RUN as a partial value and must not be relied on until o_finished.
  - After DONE, P holds unchanged in IDLE.
  - P is overwritten only on an accepted start.
- o_overflow = |P[2N-1:N]. It is combinational from P and meaningful from the DONE cycle on.
- Operand inputs are don't-care except on the accept edge. Changes during RUN have no effect.
- i_reset in any state, including mid-RUN, wins over i_start. The block returns to reset values on that edge, and the partial product is discarded.
- Width rules:
  - The adder is N bits with carry-out.
  - The carry is never lost because it shifts into P[2N-1].
  - Maximum result is (2^N-1)^2, which fits in 2N bits.
- Zero operands need no special casing; the full N iterations always run (fixed latency).

Decomposition:
- Shared package: state encoding constants (IDLE, RUN, DONE, 2-bit) and the counter width localparam clog2(N+1).
- One natural sub-module: adder, an N-bit ripple adder with carry-out, i_augend/i_addend/o_sum/o_carry. It is the mirror of the existing subtractor, instantiated once.
- The FSM, counter and accumulator stay in the top module.

Test Plan:
- N=8, A=13, B=11, start at edge 0 -> o_busy high for edges 1..8; o_finished high only in the cycle after edge 8; o_product=16'h008F; o_overflow=0.
- A=255, B=255 -> o_product=16'hFE01, o_overflow=1.
- A=0, B=200, then A=200, B=0 -> both give o_product=0, o_overflow=0, finished after exactly 9 cycles.
- Start A=3, B=5; pulse i_start with A=7, B=7 at edge 4 -> second start ignored; result 15; product held at 15 for 5 further idle cycles.
- Start A=6, B=7, assert i_reset at edge 5 -> next cycle o_busy=0, o_finished=0, o_product=0; a new start A=9, B=9 then yields 81.
- A=10, B=10; hold i_start high through DONE with A=12, B=12 presented -> o_finished one cycle with 100; second run starts with no idle cycle; o_finished 9 cycles later with 144.
